// File: rtl/hazard_stall_unit_pkg.sv
// -----------------------------------------------------------------------------
// hazard_pkg
// Shared types and constants for the hazard stall unit:
//   - br_state_e : branch-after-load FSM state (RUN, BRLD2)
//   - REG_W      : register specifier width
//   - REG_ZERO   : the hard-wired zero register, which never creates a hazard
//   - MD_LAT_DEF : default mul/div latency, EX issue to HI/LO valid
//   - reg_dep()  : source/destination match helper used for the EX and MEM
//                  dependency checks
// -----------------------------------------------------------------------------
package hazard_pkg;

    localparam int unsigned REG_W      = 5;
    localparam logic [4:0]  REG_ZERO   = 5'd0;
    localparam int unsigned MD_LAT_DEF = 4;

    typedef enum logic {
        RUN   = 1'b0,
        BRLD2 = 1'b1
    } br_state_e;

    // True when an in-flight destination feeds the ID instruction. The zero
    // register is filtered here so no caller can forget it.
    function automatic logic reg_dep(
        input logic [REG_W-1:0] dst,
        input logic [REG_W-1:0] rs,
        input logic [REG_W-1:0] rt,
        input logic             uses_rt
    );
        logic w_match;
        w_match = (dst == rs) || (uses_rt && (dst == rt));
        return (dst != REG_ZERO) && w_match;
    endfunction

endpackage : hazard_pkg

// File: rtl/hazard_stall_unit_chk.sv
// -----------------------------------------------------------------------------
// hazard_stall_unit_chk
// Property checker bound into hazard_stall_unit (simulation only).
//   clock, reset   : as the parent
//   idex_md_start  : mul/div issuing in EX
//   md_busy_int    : raw counter busy flag (not reset-gated)
// A new mul/div can only reach EX after an md_hz stall has drained the
// previous one, so an issue while busy indicates broken upstream control.
// Also guards the elaboration-time parameter ranges.
// -----------------------------------------------------------------------------
module hazard_stall_unit_chk #(
    parameter int unsigned MD_LAT = 4,
    parameter int unsigned CNT_W  = 16
) (
    input logic clock,
    input logic reset,
    input logic idex_md_start,
    input logic md_busy_int
);

    a_md_issue_while_busy : assert property (
        @(posedge clock) disable iff (!reset)
        idex_md_start |-> !md_busy_int
    ) else $error("mul/div issued while previous operation still busy");

    a_param_range : assert property (
        @(posedge clock) (MD_LAT >= 2) && (CNT_W >= 1)
    ) else $error("hazard_stall_unit parameter out of range");

endmodule : hazard_stall_unit_chk

// File: rtl/hazard_stall_unit_md_busy_counter.sv
// -----------------------------------------------------------------------------
// md_busy_counter
// Loadable down-counter tracking how long the multi-cycle mul/div unit still
// needs before HI/LO is valid. A load sets the count to MD_LAT-1; the count
// then drops by one per cycle and stops at zero.
//   clock  : pipeline clock, rising edge
//   reset  : synchronous, active-low
//   i_load : mul/div issuing in EX this cycle (reloads even when busy)
//   o_busy : count is non-zero, HI/LO not yet valid
// -----------------------------------------------------------------------------
module md_busy_counter #(
    parameter int unsigned MD_LAT = 4
) (
    input  logic clock,
    input  logic reset,
    input  logic i_load,
    output logic o_busy
);
    import hazard_pkg::*;

    // MD_LAT >= 2, so at least one bit; MD_LAT-1 always fits.
    localparam int unsigned CW = (MD_LAT > 2) ? $clog2(MD_LAT) : 1;
    localparam logic [CW-1:0] LOAD_VAL = CW'(MD_LAT - 1);

    logic [CW-1:0] r_cnt;

    // Count register: load on issue, otherwise run down to zero.
    always_ff @(posedge clock) begin
        if (!reset) begin
            r_cnt <= {CW{1'b0}};
        end else if (i_load) begin
            r_cnt <= LOAD_VAL;
        end else if (r_cnt != {CW{1'b0}}) begin
            r_cnt <= r_cnt - CW'(1);
        end else begin
            r_cnt <= r_cnt;
        end
    end

    assign o_busy = (r_cnt != {CW{1'b0}});

endmodule : md_busy_counter

// File: rtl/hazard_stall_unit.sv
// -----------------------------------------------------------------------------
// hazard_stall_unit
// Stalls the pipeline for hazards the EX forwarding network cannot bypass:
// load-use, ID-resolved branches depending on an in-flight ALU result or load,
// and HI/LO or mul/div use while the mul/div unit is still busy.
//
// Optional feature macro: HAZARD_STATS_EN adds saturating stall/bubble
// statistics counters and their output ports.
//
// Ports:
//   clock, reset             : rising-edge clock, synchronous active-low reset
//   ifid_rs/rt, ifid_uses_rt : sources of the instruction in ID
//   ifid_branch              : beq/bne compared in ID
//   ifid_hilo_rd, ifid_md_op : mfhi/mflo, mult/div in ID
//   idex_memread/regwrite/rd : instruction in EX
//   idex_md_start            : mul/div issuing in EX this cycle
//   exmem_memread/rd         : instruction in MEM
//   pc_write, ifid_write     : pipeline advance enables (0 on stall)
//   idex_bubble              : zero the ID/EX control fields
//   md_busy                  : mul/div result not yet valid
//   stall_cycles/bubble_count: statistics (HAZARD_STATS_EN only)
// Stall outputs are combinational so they act in the cycle the hazard is seen.
// -----------------------------------------------------------------------------
module hazard_stall_unit
    import hazard_pkg::*;
#(
    parameter int unsigned MD_LAT = MD_LAT_DEF,
    parameter int unsigned CNT_W  = 16
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [REG_W-1:0] ifid_rs,
    input  logic [REG_W-1:0] ifid_rt,
    input  logic             ifid_uses_rt,
    input  logic             ifid_branch,
    input  logic             ifid_hilo_rd,
    input  logic             ifid_md_op,
    input  logic             idex_memread,
    input  logic             idex_regwrite,
    input  logic [REG_W-1:0] idex_rd,
    input  logic             idex_md_start,
    input  logic             exmem_memread,
    input  logic [REG_W-1:0] exmem_rd,
    output logic             pc_write,
    output logic             ifid_write,
    output logic             idex_bubble,
    output logic             md_busy
`ifdef HAZARD_STATS_EN
    ,
    output logic [CNT_W-1:0] stall_cycles,
    output logic [CNT_W-1:0] bubble_count
`endif
);

    br_state_e r_state;
    br_state_e w_state_nxt;

    logic w_dep_ex;
    logic w_dep_mem;
    logic w_lduse;
    logic w_br_alu;
    logic w_br_ld1;
    logic w_br_ld2;
    logic w_md_busy;
    logic w_md_hz;
    logic w_stall;

    assign w_dep_ex  = reg_dep(idex_rd,  ifid_rs, ifid_rt, ifid_uses_rt);
    assign w_dep_mem = reg_dep(exmem_rd, ifid_rs, ifid_rt, ifid_uses_rt);

    assign w_lduse  = idex_memread & w_dep_ex;
    // ALU result can be forwarded to ID one cycle later; loads need two.
    assign w_br_alu = ifid_branch & idex_regwrite & ~idex_memread & w_dep_ex;
    assign w_br_ld1 = ifid_branch & w_lduse;
    assign w_br_ld2 = ifid_branch & exmem_memread & w_dep_mem;
    assign w_md_hz  = w_md_busy & (ifid_hilo_rd | ifid_md_op);

    assign w_stall = w_lduse | w_br_alu | w_br_ld2 | (r_state == BRLD2) | w_md_hz;

    md_busy_counter #(
        .MD_LAT (MD_LAT)
    ) u_md_cnt (
        .clock  (clock),
        .reset  (reset),
        .i_load (idex_md_start),
        .o_busy (w_md_busy)
    );

    // Branch FSM state register.
    always_ff @(posedge clock) begin
        if (!reset) begin
            r_state <= RUN;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Branch FSM next state: BRLD2 supplies the second bubble of a
    // branch-after-load and always returns to RUN after one cycle.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            RUN: begin
                if (w_br_ld1) begin
                    w_state_nxt = BRLD2;
                end else begin
                    w_state_nxt = RUN;
                end
            end
            BRLD2:   w_state_nxt = RUN;
            default: w_state_nxt = RUN;
        endcase
    end

    // Pipeline control outputs; reset holds the pipeline empty.
    always_comb begin
        pc_write    = 1'b0;
        ifid_write  = 1'b0;
        idex_bubble = 1'b1;
        md_busy     = 1'b0;
        if (!reset) begin
            pc_write    = 1'b0;
            ifid_write  = 1'b0;
            idex_bubble = 1'b1;
            md_busy     = 1'b0;
        end else if (w_stall) begin
            pc_write    = 1'b0;
            ifid_write  = 1'b0;
            idex_bubble = 1'b1;
            md_busy     = w_md_busy;
        end else begin
            pc_write    = 1'b1;
            ifid_write  = 1'b1;
            idex_bubble = 1'b0;
            md_busy     = w_md_busy;
        end
    end

`ifdef HAZARD_STATS_EN
    logic [CNT_W-1:0] r_stall_cycles;
    logic [CNT_W-1:0] r_bubble_count;

    // Saturating stall-cycle counter.
    always_ff @(posedge clock) begin
        if (!reset) begin
            r_stall_cycles <= {CNT_W{1'b0}};
        end else if (w_stall && (r_stall_cycles != {CNT_W{1'b1}})) begin
            r_stall_cycles <= r_stall_cycles + CNT_W'(1);
        end else begin
            r_stall_cycles <= r_stall_cycles;
        end
    end

    // Saturating bubble counter; reset cycles are excluded by the reset branch.
    always_ff @(posedge clock) begin
        if (!reset) begin
            r_bubble_count <= {CNT_W{1'b0}};
        end else if (idex_bubble && (r_bubble_count != {CNT_W{1'b1}})) begin
            r_bubble_count <= r_bubble_count + CNT_W'(1);
        end else begin
            r_bubble_count <= r_bubble_count;
        end
    end

    assign stall_cycles = r_stall_cycles;
    assign bubble_count = r_bubble_count;
`endif

`ifndef SYNTHESIS
    hazard_stall_unit_chk #(
        .MD_LAT (MD_LAT),
        .CNT_W  (CNT_W)
    ) u_chk (
        .clock         (clock),
        .reset         (reset),
        .idex_md_start (idex_md_start),
        .md_busy_int   (w_md_busy)
    );
`endif

endmodule : hazard_stall_unit

// File: tb/tb_hazard_stall_unit.sv
// Directed bench for hazard_stall_unit with hand-computed expectations.
module tb_hazard_stall_unit;
    import hazard_pkg::*;

    localparam int unsigned CNT_W = 16;

    logic             clock = 1'b0;
    logic             reset;
    logic [REG_W-1:0] ifid_rs, ifid_rt, idex_rd, exmem_rd;
    logic             ifid_uses_rt, ifid_branch, ifid_hilo_rd, ifid_md_op;
    logic             idex_memread, idex_regwrite, idex_md_start, exmem_memread;
    logic             pc_write, ifid_write, idex_bubble, md_busy;
`ifdef HAZARD_STATS_EN
    logic [CNT_W-1:0] stall_cycles, bubble_count;
`endif

    int n_checks = 0;
    int n_errors = 0;
    int exp_stalls = 0;

    hazard_stall_unit #(.MD_LAT(4), .CNT_W(CNT_W)) dut (
        .clock         (clock),
        .reset         (reset),
        .ifid_rs       (ifid_rs),
        .ifid_rt       (ifid_rt),
        .ifid_uses_rt  (ifid_uses_rt),
        .ifid_branch   (ifid_branch),
        .ifid_hilo_rd  (ifid_hilo_rd),
        .ifid_md_op    (ifid_md_op),
        .idex_memread  (idex_memread),
        .idex_regwrite (idex_regwrite),
        .idex_rd       (idex_rd),
        .idex_md_start (idex_md_start),
        .exmem_memread (exmem_memread),
        .exmem_rd      (exmem_rd),
        .pc_write      (pc_write),
        .ifid_write    (ifid_write),
        .idex_bubble   (idex_bubble),
        .md_busy       (md_busy)
`ifdef HAZARD_STATS_EN
        ,
        .stall_cycles  (stall_cycles),
        .bubble_count  (bubble_count)
`endif
    );

    always #5 clock = ~clock;

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic idle();
        ifid_rs = 5'd0; ifid_rt = 5'd0; ifid_uses_rt = 1'b0; ifid_branch = 1'b0;
        ifid_hilo_rd = 1'b0; ifid_md_op = 1'b0;
        idex_memread = 1'b0; idex_regwrite = 1'b0; idex_rd = 5'd0; idex_md_start = 1'b0;
        exmem_memread = 1'b0; exmem_rd = 5'd0;
    endtask

    // Inputs already driven; settle, check this cycle, then cross the edge.
    task automatic step(input string tag, input logic exp_stall, input logic exp_busy);
        #1;
        chk({tag, "_pc"},   32'(pc_write),    32'(!exp_stall));
        chk({tag, "_ifid"}, 32'(ifid_write),  32'(!exp_stall));
        chk({tag, "_bub"},  32'(idex_bubble), 32'(exp_stall));
        chk({tag, "_busy"}, 32'(md_busy),     32'(exp_busy));
`ifdef HAZARD_STATS_EN
        chk({tag, "_nstall"}, 32'(stall_cycles), 32'(exp_stalls));
        chk({tag, "_nbub"},   32'(bubble_count), 32'(exp_stalls));
`endif
        if (exp_stall) exp_stalls++;
        @(posedge clock); #1;
    endtask

    initial begin
        reset = 1'b0;
        idle();
        @(posedge clock); @(posedge clock); #1;
        // Reset holds the pipeline empty.
        chk("rst_pc",   32'(pc_write),    32'd0);
        chk("rst_ifid", 32'(ifid_write),  32'd0);
        chk("rst_bub",  32'(idex_bubble), 32'd1);
        chk("rst_busy", 32'(md_busy),     32'd0);
        reset = 1'b1; exp_stalls = 0;
        step("idle0", 1'b0, 1'b0);

        // Load-use, then load moves to MEM.
        idex_memread = 1'b1; idex_rd = 5'd8; ifid_rs = 5'd8;
        step("lduse", 1'b1, 1'b0);
        idle(); ifid_rs = 5'd8; exmem_memread = 1'b1; exmem_rd = 5'd8;
        step("lduse_rel", 1'b0, 1'b0);

        // Branch after load: two bubbles, second forced by BRLD2.
        idle(); ifid_branch = 1'b1; ifid_rs = 5'd9; idex_memread = 1'b1; idex_rd = 5'd9;
        step("brld1", 1'b1, 1'b0);
        idle(); ifid_branch = 1'b1; ifid_rs = 5'd9;
        step("brld2", 1'b1, 1'b0);
        step("brld_rel", 1'b0, 1'b0);

        // Branch after ALU op via rt: one bubble.
        idle(); ifid_branch = 1'b1; ifid_rs = 5'd3; ifid_rt = 5'd10; ifid_uses_rt = 1'b1;
        idex_regwrite = 1'b1; idex_rd = 5'd10;
        step("bralu", 1'b1, 1'b0);
        idle(); ifid_branch = 1'b1; ifid_rs = 5'd3; ifid_rt = 5'd10; ifid_uses_rt = 1'b1;
        exmem_rd = 5'd10;
        step("bralu_rel", 1'b0, 1'b0);

        // rt match ignored when rt is not a source.
        idle(); idex_memread = 1'b1; idex_rd = 5'd11; ifid_rt = 5'd11; ifid_rs = 5'd2;
        step("no_rt", 1'b0, 1'b0);

        // Branch with load already in MEM: one bubble, no FSM state.
        idle(); ifid_branch = 1'b1; ifid_rs = 5'd12; exmem_memread = 1'b1; exmem_rd = 5'd12;
        step("brld_mem", 1'b1, 1'b0);
        idle();
        step("brld_mem_rel", 1'b0, 1'b0);

        // Register zero never hazards.
        idle(); idex_memread = 1'b1; idex_rd = 5'd0; ifid_rs = 5'd0;
        ifid_branch = 1'b1; exmem_memread = 1'b1;
        step("reg0", 1'b0, 1'b0);

        // Mul/div wait with mfhi held in ID.
        idle(); idex_md_start = 1'b1;
        step("md_issue", 1'b0, 1'b0);
        idle(); ifid_hilo_rd = 1'b1;
        step("md_w3", 1'b1, 1'b1);
        step("md_w2", 1'b1, 1'b1);
        step("md_w1", 1'b1, 1'b1);
        step("md_done", 1'b0, 1'b0);

        // Busy but unrelated instruction in ID; then a mult in ID stalls.
        idle(); idex_md_start = 1'b1;
        step("md2_issue", 1'b0, 1'b0);
        idle();
        step("md2_free", 1'b0, 1'b1);
        ifid_md_op = 1'b1;
        step("md2_mdop", 1'b1, 1'b1);
        idle();
        step("md2_last", 1'b0, 1'b1);
        step("md2_done", 1'b0, 1'b0);

        // Reset while in BRLD2 with a mul/div in flight.
        idle(); ifid_branch = 1'b1; ifid_rs = 5'd9; idex_memread = 1'b1; idex_rd = 5'd9;
        idex_md_start = 1'b1;
        step("pre_rst", 1'b1, 1'b0);
        idle(); reset = 1'b0;
        #1;
        chk("mid_rst_pc",   32'(pc_write),    32'd0);
        chk("mid_rst_bub",  32'(idex_bubble), 32'd1);
        chk("mid_rst_busy", 32'(md_busy),     32'd0);
        @(posedge clock); #1;
        reset = 1'b1; exp_stalls = 0;
        step("post_rst", 1'b0, 1'b0);
        step("post_rst2", 1'b0, 1'b0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule : tb_hazard_stall_unit

// File: doc/hazard_stall_unit.md
Name: hazard_stall_unit

Overview:
- Pipeline-control partner of the EX-stage forwarding logic. Forwarding fixes hazards the pipeline can bypass; this block stalls for the ones it cannot.
- Sits at IF/ID–ID/EX and drives PC write-enable, IF/ID write-enable and the ID/EX bubble (control-zero) select.
- Covers three cases: load-use, a branch resolved in ID that depends on an in-flight load or ALU result, and HI/LO or mul/div use while the multi-cycle mul/div unit is busy.

Parameters:
- MD_LAT, 4, mul/div latency in cycles from EX issue to HI/LO valid. Legal range ≥2.
- CNT_W, 16, width of the statistics counters (optional feature only).

Ports:
- clock  in  1  pipeline clock, rising edge
- reset  in  1  synchronous, active-low reset
- ifid_rs  in  5  rs of instruction in ID
- ifid_rt  in  5  rt of instruction in ID
- ifid_uses_rt  in  1  ID instruction reads rt as a source
- ifid_branch  in  1  ID instruction is beq/bne (compared in ID)
- ifid_hilo_rd  in  1  ID instruction is mfhi/mflo
- ifid_md_op  in  1  ID instruction is mult/div
- idex_memread  in  1  EX instruction is a load
- idex_regwrite  in  1  EX instruction writes the register file
- idex_rd  in  5  EX destination register (already muxed rt/rd)
- idex_md_start  in  1  mul/div issuing in EX this cycle
- exmem_memread  in  1  MEM instruction is a load
- exmem_rd  in  5  MEM destination register
- pc_write  out  1  PC update enable
- ifid_write  out  1  IF/ID register enable
- idex_bubble  out  1  zero ID/EX control fields
- md_busy  out  1  mul/div result not yet valid
- stall_cycles  out  CNT_W  stall cycle count (HAZARD_STATS_EN only)
- bubble_count  out  CNT_W  inserted bubble count (HAZARD_STATS_EN only)

Behaviour:
- Register 0 never causes a hazard. Every match requires a destination ≠ 0.
- dep_ex: idex_rd ≠ 0 and (idex_rd == ifid_rs, or ifid_uses_rt and idex_rd == ifid_rt).
- dep_mem: the same match against exmem_rd.
- lduse = idex_memread & dep_ex.
- br_alu = ifid_branch & idex_regwrite & ~idex_memread & dep_ex (1 bubble).
- br_ld1 = ifid_branch & lduse (2 bubbles).
- br_ld2 = ifid_branch & exmem_memread & dep_mem (1 bubble; load is in MEM).
- Branch FSM states: RUN and BRLD2.
  - RUN → BRLD2 when br_ld1.
  - BRLD2 → RUN unconditionally after 1 cycle.
  - In BRLD2 the stall is forced regardless of inputs.
- Mul/div counter (md_cnt):
  - On idex_md_start, load MD_LAT-1.
  - While non-zero, decrement by 1 per cycle.
  - md_busy = (md_cnt ≠ 0).
  - md_hz = md_busy & (ifid_hilo_rd | ifid_md_op).
  - idex_md_start while already busy reloads the counter. This cannot happen without a prior md_hz stall and is flagged by an assertion.
- stall = lduse | br_alu | br_ld2 | (state == BRLD2) | md_hz.
- Stall outputs are combinational from registered state plus current inputs, taking effect the same cycle:
  - When stall: pc_write=0, ifid_write=0, idex_bubble=1.
  - Otherwise: 1, 1, 0.
- Simultaneous conditions OR together; no priority is needed. BRLD2 and md_cnt advance independently.
- Reset (reset=0 at a clock edge): state=RUN, md_cnt=0, counters=0.
- While reset is low, outputs are pc_write=0, ifid_write=0, idex_bubble=1, md_busy=0. This holds the pipeline empty.
- Reset mid-stall aborts BRLD2 and any mul/div wait.

Optional Feature:
- Macro HAZARD_STATS_EN.
- When defined:
  - stall_cycles increments on every stall cycle.
  - bubble_count increments whenever idex_bubble=1 outside reset.
  - Both saturate at all-ones and clear on reset.
- When undefined: the ports are absent and no counter logic is generated.

Decomposition:
- Package hazard_pkg holds:
  - branch-FSM state typedef (RUN, BRLD2)
  - REG_ZERO=5'd0
  - default MD_LAT
  - REG_W=5
- Sub-module md_busy_counter: MD_LAT-parameterised loadable down-counter with busy flag, instantiated once.

Test Plan:
- Load-use:
  - Stimulus: idex_memread=1, idex_rd=8, ifid_rs=8, ifid_branch=0.
  - Response: one cycle pc_write=0, ifid_write=0, idex_bubble=1; next cycle (load moved to MEM) returns to 1,1,0.
- Branch after load:
  - Stimulus: ifid_branch=1, ifid_rs=9, idex_memread=1, idex_rd=9.
  - Response: two consecutive bubbles, the second via BRLD2, then pc_write=1.
- Branch after ALU op:
  - Stimulus: ifid_branch=1, idex_regwrite=1, idex_rd=10, ifid_rt=10, ifid_uses_rt=1.
  - Response: exactly one bubble.
- Register-zero filter:
  - Stimulus: idex_memread=1, idex_rd=0, ifid_rs=0.
  - Response: no stall.
- Mul/div wait:
  - Stimulus: idex_md_start pulse with MD_LAT=4, then mfhi held in ID.
  - Response: md_busy high for 3 cycles; stalls for those 3 cycles; releases when md_cnt reaches 0. With a non-HI/LO instruction in ID, no stall.
- Reset during BRLD2:
  - Stimulus: reset=0 for one edge.
  - Response: state=RUN, md_busy=0; with HAZARD_STATS_EN, stall_cycles=0.
  - Response after release with no hazards: pc_write=1.
